// File: rtl/mmio_responder_pkg.sv
// Shared types for the dmem bus and the IO window: access opcodes, register
// offsets, timer control layout and the load extension helper.
package mmio_responder_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        LOAD_STORE_NONE    = 4'd0,
        LOAD_BYTE          = 4'd1,
        LOAD_HALF          = 4'd2,
        LOAD_WORD          = 4'd3,
        LOAD_BYTE_UNSIGNED = 4'd4,
        LOAD_HALF_UNSIGNED = 4'd5,
        STORE_BYTE         = 4'd6,
        STORE_HALF         = 4'd7,
        STORE_WORD         = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    localparam logic [11:0] MMIO_GPIO_OUT   = 12'h000;
    localparam logic [11:0] MMIO_GPIO_TRI   = 12'h004;
    localparam logic [11:0] MMIO_GPIO_IN    = 12'h008;
    localparam logic [11:0] MMIO_TMR_COUNT  = 12'h010;
    localparam logic [11:0] MMIO_TMR_CMP    = 12'h014;
    localparam logic [11:0] MMIO_TMR_CTRL   = 12'h018;
    localparam logic [11:0] MMIO_IRQ_STATUS = 12'h01C;

    typedef struct packed {
        logic reload;
        logic ie;
        logic en;
    } tmr_ctrl_t;

    function automatic logic is_load(input mem_op_t op);
        return (op == LOAD_BYTE) || (op == LOAD_HALF) || (op == LOAD_WORD) ||
               (op == LOAD_BYTE_UNSIGNED) || (op == LOAD_HALF_UNSIGNED);
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return (op == STORE_BYTE) || (op == STORE_HALF) || (op == STORE_WORD);
    endfunction

    function automatic acc_size_t access_size(input mem_op_t op);
        acc_size_t sz;
        case (op)
            LOAD_BYTE, LOAD_BYTE_UNSIGNED, STORE_BYTE: sz = SZ_BYTE;
            LOAD_HALF, LOAD_HALF_UNSIGNED, STORE_HALF: sz = SZ_HALF;
            default:                                   sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Picks the addressed lane out of an aligned word and extends it to 32 bits.
    function automatic word_t load_extend(input mem_op_t op, input logic [1:0] off,
                                          input word_t word);
        logic [7:0]  b;
        logic [15:0] h;
        word_t       r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            LOAD_BYTE:          r = {{24{b[7]}}, b};
            LOAD_BYTE_UNSIGNED: r = {24'd0, b};
            LOAD_HALF:          r = {{16{h[15]}}, h};
            LOAD_HALF_UNSIGNED: r = {16'd0, h};
            LOAD_WORD:          r = word;
            default:            r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mmio_responder_timer.sv
// 32-bit compare timer: free-running count with optional auto-reload on
// match, sticky pending flag (write-one-to-clear) and a level interrupt.
module mmio_responder_timer
    import mmio_responder_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic [31:0] count_wdata,
    input  logic        cmp_we,
    input  logic [31:0] cmp_wdata,
    input  logic        ctrl_we,
    input  logic [2:0]  ctrl_wdata,
    input  logic        pend_clr,
    output logic [31:0] count,
    output logic [31:0] cmp,
    output logic [2:0]  ctrl,
    output logic        pend,
    output logic        irq
);

    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    tmr_ctrl_t   ctrl_q, ctrl_d;
    logic        pend_q, pend_d;
    logic        match;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            cmp_q   <= '0;
            ctrl_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        match  = ctrl_q.en && (count_q == cmp_q);
        cmp_d  = cmp_we ? cmp_wdata : cmp_q;
        ctrl_d = ctrl_we ? tmr_ctrl_t'(ctrl_wdata) : ctrl_q;

        // A software write to COUNT overrides both increment and reload.
        count_d = count_q;
        if (count_we) begin
            count_d = count_wdata;
        end else if (ctrl_q.en) begin
            count_d = (match && ctrl_q.reload) ? 32'd0 : count_q + 32'd1;
        end

        // Set has priority so a match is never lost to a coincident clear.
        pend_d = pend_q;
        if (pend_clr) begin
            pend_d = 1'b0;
        end
        if (match) begin
            pend_d = 1'b1;
        end
    end

    assign count = count_q;
    assign cmp   = cmp_q;
    assign ctrl  = ctrl_q;
    assign pend  = pend_q;
    assign irq   = pend_q & ctrl_q.ie;

endmodule

// File: rtl/mmio_responder.sv
// IO-window responder on the dmem bus: GPIO out/tristate/in registers and a
// compare timer, with one-cycle registered load data and fault pulse.
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter logic [31:0] TRI_RESET   = 32'hFFFF_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  mem_op_t     dmem_op,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_error,
    input  logic [31:0] gpio_i,
    output logic [31:0] gpio_o,
    output logic [31:0] gpio_t,
    output logic        interrupt
);

    logic [31:0] gpio_out_q, gpio_out_d;
    logic [31:0] gpio_tri_q, gpio_tri_d;
    logic [31:0] sync_q [SYNC_STAGES];
    logic [31:0] sync_d [SYNC_STAGES];
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        sel, ld, st, misaligned, mapped, fault, wr;
    logic [11:0] offset;
    acc_size_t   size;
    logic [3:0]  be;
    logic [31:0] wdata_shift, lane_mask, read_word, merged;

    logic [31:0] tmr_count, tmr_cmp;
    logic [2:0]  tmr_ctrl;
    logic        tmr_pend, tmr_irq;

    assign offset = dmem_addr[11:0];
    assign size   = access_size(dmem_op);

    genvar gi;

    // Pad input synchronizer chain; the last stage is what software reads.
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = gpio_i;
            end else begin : g_rest
                assign sync_d[gi] = sync_q[gi-1];
            end
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    sync_q[gi] <= '0;
                end else begin
                    sync_q[gi] <= sync_d[gi];
                end
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[8*gi +: 8] = {8{be[gi]}};
        end
    endgenerate

    always_comb begin
        sel = (dmem_op != LOAD_STORE_NONE) && (dmem_addr[31:12] == BASE_ADDR[31:12]);
        ld  = is_load(dmem_op);
        st  = is_store(dmem_op);

        case (size)
            SZ_WORD: misaligned = (dmem_addr[1:0] != 2'b00);
            SZ_HALF: misaligned = dmem_addr[0];
            default: misaligned = 1'b0;
        endcase

        mapped    = 1'b1;
        read_word = '0;
        case ({offset[11:2], 2'b00})
            MMIO_GPIO_OUT:   read_word = gpio_out_q;
            MMIO_GPIO_TRI:   read_word = gpio_tri_q;
            MMIO_GPIO_IN:    read_word = sync_q[SYNC_STAGES-1];
            MMIO_TMR_COUNT:  read_word = tmr_count;
            MMIO_TMR_CMP:    read_word = tmr_cmp;
            MMIO_TMR_CTRL:   read_word = {29'd0, tmr_ctrl};
            MMIO_IRQ_STATUS: read_word = {31'd0, tmr_pend};
            default:         mapped    = 1'b0;
        endcase

        fault = sel && (misaligned || !mapped);
        wr    = sel && st && !fault;

        case (size)
            SZ_BYTE: begin
                wdata_shift = {4{dmem_wdata[7:0]}};
                be          = 4'b0001 << dmem_addr[1:0];
            end
            SZ_HALF: begin
                wdata_shift = {2{dmem_wdata[15:0]}};
                be          = dmem_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_shift = dmem_wdata;
                be          = 4'b1111;
            end
        endcase

        // Sub-word stores keep the untouched lanes of the current value.
        merged = (read_word & ~lane_mask) | (wdata_shift & lane_mask);
    end

    logic we_out, we_tri, we_count, we_cmp, we_ctrl, we_status;

    always_comb begin
        we_out    = wr && ({offset[11:2], 2'b00} == MMIO_GPIO_OUT);
        we_tri    = wr && ({offset[11:2], 2'b00} == MMIO_GPIO_TRI);
        we_count  = wr && ({offset[11:2], 2'b00} == MMIO_TMR_COUNT);
        we_cmp    = wr && ({offset[11:2], 2'b00} == MMIO_TMR_CMP);
        we_ctrl   = wr && ({offset[11:2], 2'b00} == MMIO_TMR_CTRL);
        we_status = wr && ({offset[11:2], 2'b00} == MMIO_IRQ_STATUS);

        gpio_out_d = we_out ? merged : gpio_out_q;
        gpio_tri_d = we_tri ? merged : gpio_tri_q;

        rdata_d = (sel && ld && !fault) ? load_extend(dmem_op, dmem_addr[1:0], read_word) : '0;
        error_d = fault;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gpio_out_q <= '0;
            gpio_tri_q <= TRI_RESET;
            rdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            gpio_tri_q <= gpio_tri_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
        end
    end

    // Pend clears only when lane 0 is actually written with bit 0 set.
    mmio_responder_timer u_timer (
        .clk         (clk),
        .resetn      (resetn),
        .count_we    (we_count),
        .count_wdata (merged),
        .cmp_we      (we_cmp),
        .cmp_wdata   (merged),
        .ctrl_we     (we_ctrl),
        .ctrl_wdata  (merged[2:0]),
        .pend_clr    (we_status && be[0] && wdata_shift[0]),
        .count       (tmr_count),
        .cmp         (tmr_cmp),
        .ctrl        (tmr_ctrl),
        .pend        (tmr_pend),
        .irq         (tmr_irq)
    );

    assign dmem_rdata = rdata_q;
    assign dmem_error = error_q;
    assign gpio_o     = gpio_out_q;
    assign gpio_t     = gpio_tri_q;
    assign interrupt  = tmr_irq;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: stimulus pushes expected responses into a
// queue, a monitor pops one per cycle and compares rdata/error.
module tb_mmio_responder;
    import mmio_responder_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    mem_op_t     dmem_op = LOAD_STORE_NONE;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_error;
    logic [31:0] gpio_i = '0;
    logic [31:0] gpio_o;
    logic [31:0] gpio_t;
    logic        interrupt;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    mmio_responder #(
        .BASE_ADDR   (32'h0000_1000),
        .TRI_RESET   (32'hFFFF_0000),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .dmem_op    (dmem_op),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_error (dmem_error),
        .gpio_i     (gpio_i),
        .gpio_o     (gpio_o),
        .gpio_t     (gpio_t),
        .interrupt  (interrupt)
    );

    // One bus cycle: drive on the falling edge, expected response due after the next rising edge.
    task automatic cyc(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input string nm);
        exp_t e;
        @(negedge clk);
        dmem_op    = op;
        dmem_addr  = addr;
        dmem_wdata = wd;
        e.rd   = exp_rd;
        e.err  = exp_err;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(LOAD_STORE_NONE, 32'h0, 32'h0, 32'h0, 1'b0, "idle");
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end else begin
            $display("ok   %s = %h", nm, act);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (dmem_rdata !== e.rd || dmem_error !== e.err) begin
                    n_bad++;
                    $display("FAIL %s: rdata=%h error=%b, expected rdata=%h error=%b",
                             e.name, dmem_rdata, dmem_error, e.rd, e.err);
                end else if (e.name != "idle") begin
                    $display("ok   %s: rdata=%h error=%b", e.name, dmem_rdata, dmem_error);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Reset state
        chk("reset gpio_t", gpio_t, 32'hFFFF_0000);
        chk("reset gpio_o", gpio_o, 32'h0);
        chk("reset interrupt", {31'd0, interrupt}, 32'h0);
        cyc(LOAD_WORD, 32'h1004, 0, 32'hFFFF_0000, 0, "lw tri reset");

        // Lane merge and load extension
        cyc(STORE_WORD, 32'h1000, 32'h1122_3344, 0, 0, "sw out");
        cyc(STORE_BYTE, 32'h1002, 32'h0000_00A5, 0, 0, "sb out lane2");
        idle(1);
        chk("gpio_o after sb", gpio_o, 32'h11A5_3344);
        cyc(LOAD_BYTE, 32'h1002, 0, 32'hFFFF_FFA5, 0, "lb lane2");
        cyc(LOAD_BYTE_UNSIGNED, 32'h1002, 0, 32'h0000_00A5, 0, "lbu lane2");
        cyc(LOAD_BYTE, 32'h1003, 0, 32'h0000_0011, 0, "lb lane3");
        cyc(LOAD_HALF, 32'h1000, 0, 32'h0000_3344, 0, "lh low");
        cyc(LOAD_HALF_UNSIGNED, 32'h1002, 0, 32'h0000_11A5, 0, "lhu high");
        cyc(STORE_HALF, 32'h1006, 32'hDEAD_8234, 0, 0, "sh tri high");
        idle(1);
        chk("gpio_t after sh", gpio_t, 32'h8234_0000);
        cyc(LOAD_HALF, 32'h1006, 0, 32'hFFFF_8234, 0, "lh tri high");

        // Faults and read-only input register
        cyc(LOAD_HALF, 32'h1001, 0, 0, 1, "lh misaligned");
        cyc(LOAD_WORD, 32'h1020, 0, 0, 1, "lw unmapped");
        cyc(LOAD_WORD, 32'h100C, 0, 0, 1, "lw gap");
        cyc(STORE_WORD, 32'h1008, 32'hFFFF_FFFF, 0, 0, "sw gpio_in");
        cyc(STORE_WORD, 32'h1002, 32'hFFFF_FFFF, 0, 1, "sw misaligned");
        cyc(STORE_BYTE, 32'h1024, 32'hFF, 0, 1, "sb unmapped");
        cyc(LOAD_WORD, 32'h1000, 0, 32'h11A5_3344, 0, "lw out unchanged");
        idle(1);
        chk("gpio_t unchanged", gpio_t, 32'h8234_0000);

        // Input synchronizer latency
        cyc(LOAD_WORD, 32'h1008, 0, 32'h0, 0, "lw gpio_in pre");
        gpio_i = 32'h0000_0001;
        cyc(LOAD_WORD, 32'h1008, 0, 32'h0, 0, "lw gpio_in +1");
        cyc(LOAD_WORD, 32'h1008, 0, 32'h1, 0, "lw gpio_in +2");

        // Timer compare with reload and interrupt
        cyc(STORE_WORD, 32'h1014, 32'd5, 0, 0, "sw cmp");
        cyc(STORE_WORD, 32'h1018, 32'h7, 0, 0, "sw ctrl 111");
        cyc(LOAD_WORD, 32'h1010, 0, 32'd0, 0, "lw count 0");
        idle(3);
        cyc(LOAD_WORD, 32'h1010, 0, 32'd4, 0, "lw count 4");
        cyc(LOAD_WORD, 32'h101C, 0, 32'd0, 0, "lw status pre");
        chk("irq before match", {31'd0, interrupt}, 32'h0);
        cyc(LOAD_WORD, 32'h1010, 0, 32'd0, 0, "lw count reloaded");
        chk("irq after match", {31'd0, interrupt}, 32'h1);
        cyc(LOAD_WORD, 32'h101C, 0, 32'd1, 0, "lw status pend");
        cyc(STORE_WORD, 32'h101C, 32'h1, 0, 0, "w1c pend");
        cyc(STORE_WORD, 32'h1018, 32'h0, 0, 0, "sw ctrl off");
        chk("irq after w1c", {31'd0, interrupt}, 32'h0);
        cyc(LOAD_WORD, 32'h1010, 0, 32'd4, 0, "lw count frozen a");
        cyc(LOAD_WORD, 32'h1010, 0, 32'd4, 0, "lw count frozen b");

        // Software write beats increment; sub-word merge into COUNT
        cyc(STORE_WORD, 32'h1018, 32'h1, 0, 0, "sw ctrl en");
        cyc(STORE_WORD, 32'h1010, 32'h100, 0, 0, "sw count");
        cyc(LOAD_WORD, 32'h1010, 0, 32'h100, 0, "lw count written");
        cyc(STORE_WORD, 32'h1018, 32'h0, 0, 0, "sw ctrl off 2");
        cyc(STORE_BYTE, 32'h1011, 32'hAB, 0, 0, "sb count lane1");
        cyc(LOAD_WORD, 32'h1010, 0, 32'h0000_AB02, 0, "lw count merged");

        // Outside the window and idle-with-address are ignored
        cyc(LOAD_WORD, 32'h0000_2004, 0, 0, 0, "lw outside");
        cyc(STORE_WORD, 32'h0000_2000, 32'hDEAD_BEEF, 0, 0, "sw outside");
        cyc(LOAD_STORE_NONE, 32'h1000, 32'hFFFF_FFFF, 0, 0, "none in window");
        cyc(LOAD_WORD, 32'h1000, 0, 32'h11A5_3344, 0, "lw out after ignored");

        // Reset in the middle of a running count and an access
        cyc(STORE_WORD, 32'h1018, 32'h3, 0, 0, "sw ctrl en ie");
        idle(3);
        cyc(LOAD_WORD, 32'h1010, 0, 0, 0, "lw killed by reset");
        #2;
        resetn = 1'b0;
        dmem_op = LOAD_STORE_NONE;
        @(negedge clk);
        resetn = 1'b1;
        idle(1);
        chk("post-reset gpio_t", gpio_t, 32'hFFFF_0000);
        chk("post-reset gpio_o", gpio_o, 32'h0);
        chk("post-reset interrupt", {31'd0, interrupt}, 32'h0);
        cyc(LOAD_WORD, 32'h1010, 0, 32'h0, 0, "lw count after reset");
        cyc(LOAD_WORD, 32'h101C, 0, 32'h0, 0, "lw status after reset");
        cyc(LOAD_WORD, 32'h1018, 0, 32'h0, 0, "lw ctrl after reset");
        idle(2);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
